uart_tx_param: RTL and testbench

Parametrised successor to the existing single-rate UART transmitter. It serialises DATA_WIDTH-bit words into UART frames: start bit, data LSB first, optional even/odd parity, then one or two stop bits. The bit period is set at run time by a clock-divider value. A FIFO_DEPTH-entry input FIFO with a valid/ready handshake allows back-to-back frames with no idle gap. It sits in the TX clock domain between the system-side producer and the serial line.

---
 rtl/uart_tx_param.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Small synchronous FIFO: valid/ready on both sides, pointers wrap modulo DEPTH.
// Latency: a word written at edge N is visible at the head after edge N.
// Backpressure: in_rdy is !full from the registered count and ignores a same-cycle pop.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         core_clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en;
    logic          rd_en;

    assign in_rdy  = (count_q != FULL_CNT);
    assign out_vld = (count_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign wr_en   = in_vld && in_rdy;
    assign rd_en   = out_rdy && out_vld;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count guards every read.
    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_dat;
        end
    end
endmodule

// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, one or two stops.
// Latency: word pushed at edge N is popped at N+1; TX_OUT shows the start bit after N+2.
// Backpressure: Ready is !full of the input FIFO; queued words go out back-to-back.
module uart_tx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    output logic                      Ready,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      fifo_empty
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic [PW-1:0]         prescale_q, prescale_d;
    logic [PW-1:0]         div_cnt_q, div_cnt_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;

    logic                  fifo_vld;
    logic [DATA_WIDTH-1:0] fifo_dat;
    logic                  load;
    logic                  bit_done;
    logic                  line_bit;
    logic [PW-1:0]         eff_prescale;

    uart_tx_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (CLK),
        .rst_n    (RST),
        .in_vld   (Data_Valid),
        .in_rdy   (Ready),
        .in_dat   (P_DATA),
        .out_vld  (fifo_vld),
        .out_rdy  (load),
        .out_dat  (fifo_dat)
    );

    assign eff_prescale = (Prescale == '0) ? PW'(1) : Prescale;
    assign bit_done     = (div_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        prescale_d = prescale_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q - PW'(1);
        line_bit   = 1'b1;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = div_cnt_q;
                load      = fifo_vld;
            end
            ST_START: begin
                line_bit = 1'b0;
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                line_bit = shift_q[0];
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_PARITY: begin
                line_bit = par_bit_q;
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // bit_cnt counts stop bits already sent; a queued word skips IDLE.
                if (bit_done) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = CW'(1);
                    end else if (fifo_vld) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bit_done && (state_q != ST_IDLE)) begin
            div_cnt_d = prescale_q - PW'(1);
        end

        // Frame configuration is sampled only here and held until the next load.
        if (load) begin
            state_d    = ST_START;
            shift_d    = fifo_dat;
            par_bit_d  = (^fifo_dat) ^ PAR_TYP;
            par_en_d   = PAR_EN;
            stop2_d    = STOP2;
            prescale_d = eff_prescale;
            div_cnt_d  = eff_prescale - PW'(1);
            bit_cnt_d  = '0;
        end

        tx_out_d = line_bit;
        busy_d   = (state_q != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            prescale_q <= PW'(1);
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            prescale_q <= prescale_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_OUT     = tx_out_q;
    assign busy       = busy_q;
    assign fifo_empty = !fifo_vld;
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: directed vector table, multi-cycle corner sequences,
// and randomized batches checked against a frame-level line model.
module tb_uart_tx_param;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Ready;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic [PW-1:0] Prescale;
    logic          TX_OUT;
    logic          busy;
    logic          fifo_empty;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_param #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW),
        .FIFO_DEPTH     (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Ready      (Ready),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .fifo_empty (fifo_empty)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [DW-1:0] word;
        logic [PW-1:0] pre;
        bit            pe;
        bit            pt;
        bit            st2;
        int            exp_len;
        bit            exp_par;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic push(input logic [DW-1:0] w);
        int g;
        g = 0;
        while (Ready !== 1'b1 && g < 500) begin
            tick();
            g++;
        end
        check("push_ready", Ready, 1);
        P_DATA     = w;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
    endtask

    task automatic wait_start(input int maxc, output int waited);
        waited = 0;
        while (TX_OUT !== 1'b0 && waited < maxc) begin
            tick();
            waited++;
        end
    endtask

    // Current sample must be the first clock of the start bit.
    task automatic expect_frame(input string name, input logic [DW-1:0] w, input int p,
                                input bit pe, input bit par, input int len);
        int   peff;
        int   b;
        int   bad_tx;
        int   bad_busy;
        logic e;
        peff     = (p == 0) ? 1 : p;
        bad_tx   = 0;
        bad_busy = 0;
        for (int i = 0; i < len; i++) begin
            b = i / peff;
            if (b == 0) e = 1'b0;
            else if (b <= DW) e = w[b-1];
            else if (pe && b == DW + 1) e = par;
            else e = 1'b1;
            if (TX_OUT !== e) bad_tx++;
            if (busy !== 1'b1) bad_busy++;
            tick();
        end
        check({name, "_wave_bad_samples"}, bad_tx, 0);
        check({name, "_busy_low_samples"}, bad_busy, 0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_tx"}, TX_OUT, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_empty"}, fifo_empty, 1);
    endtask

    task automatic run_batch();
        logic [DW-1:0] words[$];
        int nw;
        int p;
        bit pe;
        bit pt;
        bit st2;
        int ws;
        int len;
        nw  = $urandom_range(1, 6);
        p   = $urandom_range(0, 5);
        pe  = 1'($urandom_range(0, 1));
        pt  = 1'($urandom_range(0, 1));
        st2 = 1'($urandom_range(0, 1));
        for (int j = 0; j < nw; j++) words.push_back(DW'($urandom_range(0, 255)));
        len = ((p == 0) ? 1 : p) * (1 + DW + int'(pe) + 1 + int'(st2));
        Prescale = PW'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = st2;
        fork
            begin
                for (int j = 0; j < nw; j++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    push(words[j]);
                end
            end
            begin
                for (int j = 0; j < nw; j++) begin
                    wait_start(400, ws);
                    check("rnd_start_seen", (ws < 400) ? 1 : 0, 1);
                    expect_frame("rnd", words[j], p, pe, (^words[j]) ^ pt, len);
                end
            end
        join
        check_idle("rnd_idle");
    endtask

    initial begin
        logic [DW-1:0] b2b[5];
        int ws;
        int bad;

        vecs[0] = '{word: 8'hB4, pre: 6'd1, pe: 1'b0, pt: 1'b0, st2: 1'b0, exp_len: 10, exp_par: 1'b0};
        vecs[1] = '{word: 8'hA5, pre: 6'd4, pe: 1'b1, pt: 1'b0, st2: 1'b1, exp_len: 48, exp_par: 1'b0};
        vecs[2] = '{word: 8'hA5, pre: 6'd4, pe: 1'b1, pt: 1'b1, st2: 1'b1, exp_len: 48, exp_par: 1'b1};
        vecs[3] = '{word: 8'h0F, pre: 6'd0, pe: 1'b0, pt: 1'b0, st2: 1'b0, exp_len: 10, exp_par: 1'b0};
        vecs[4] = '{word: 8'h3C, pre: 6'd3, pe: 1'b1, pt: 1'b1, st2: 1'b0, exp_len: 33, exp_par: 1'b1};
        vecs[5] = '{word: 8'h01, pre: 6'd2, pe: 1'b1, pt: 1'b0, st2: 1'b1, exp_len: 24, exp_par: 1'b1};

        RST        = 1'b0;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        Prescale   = 6'd1;
        repeat (3) tick();
        check("reset_tx", TX_OUT, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", Ready, 1);
        check("reset_empty", fifo_empty, 1);
        RST = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            Prescale = vecs[k].pre;
            PAR_EN   = vecs[k].pe;
            PAR_TYP  = vecs[k].pt;
            STOP2    = vecs[k].st2;
            push(vecs[k].word);
            check("vec_tx_after_push", TX_OUT, 1);
            tick();
            check("vec_tx_after_pop", TX_OUT, 1);
            check("vec_busy_after_pop", busy, 0);
            tick();
            expect_frame("vec", vecs[k].word, int'(vecs[k].pre), vecs[k].pe, vecs[k].exp_par,
                         vecs[k].exp_len);
            check_idle("vec_idle");
            repeat (2) tick();
            check("vec_tx_stays_high", TX_OUT, 1);
        end

        // Five consecutive pushes at one clock per bit: FIFO fills, frames abut.
        b2b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        Prescale = 6'd1;
        PAR_EN   = 1'b0;
        STOP2    = 1'b0;
        fork
            begin
                for (int j = 0; j < 5; j++) begin
                    check("b2b_ready_before_push", Ready, 1);
                    push(b2b[j]);
                end
                check("b2b_ready_low_when_full", Ready, 0);
                check("b2b_not_empty", fifo_empty, 0);
            end
            begin
                wait_start(20, ws);
                check("b2b_first_latency", ws, 3);
                for (int j = 0; j < 5; j++) begin
                    if (j > 0) begin
                        wait_start(20, ws);
                        check("b2b_gap", ws, 0);
                    end
                    expect_frame("b2b", b2b[j], 1, 1'b0, 1'b0, 10);
                end
            end
        join
        check_idle("b2b_idle");

        // Config changes mid-frame apply only to the following frame.
        Prescale = 6'd2;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        push(8'h5A);
        tick();
        tick();
        fork
            begin
                expect_frame("mid_first", 8'h5A, 2, 1'b0, 1'b0, 20);
                wait_start(20, ws);
                check("mid_gap", ws, 0);
                expect_frame("mid_second", 8'hC3, 5, 1'b1, 1'b0, 55);
            end
            begin
                repeat (6) tick();
                Prescale = 6'd5;
                PAR_EN   = 1'b1;
                PAR_TYP  = 1'b0;
                push(8'hC3);
            end
        join
        check_idle("mid_idle");

        // Reset during DATA with three words queued.
        Prescale = 6'd2;
        PAR_EN   = 1'b0;
        push(8'h81);
        push(8'h42);
        push(8'h24);
        push(8'h18);
        repeat (4) tick();
        check("rst_pre_busy", busy, 1);
        check("rst_pre_not_empty", fifo_empty, 0);
        RST = 1'b0;
        tick();
        check("rst_mid_tx", TX_OUT, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_empty", fifo_empty, 1);
        check("rst_mid_ready", Ready, 1);
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1) bad++;
        end
        check("rst_no_residual_frame", bad, 0);
        push(8'h96);
        tick();
        tick();
        expect_frame("rst_recover", 8'h96, 2, 1'b0, 1'b0, 20);
        check_idle("rst_recover_idle");

        for (int bi = 0; bi < 10; bi++) run_batch();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
